// File: rtl/gg_vlc_bit_packer.sv
// Packs right-justified VLC codewords MSB-first into WID-bit words with an aligned mb_start marker lane.
// A completed word appears the cycle after acceptance; in_ready drops once more than WID bits are pending.
module gg_vlc_bit_packer #(
  parameter int WID    = 32,
  parameter int MAXLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MAXLEN-1:0] in_code,
  input  logic [5:0]        in_len,
  input  logic              in_mb_start,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WID-1:0]    out_bits,
  output logic [WID-1:0]    out_mb_start,
  output logic              out_last,
  output logic              flush_done,
  output logic [31:0]       bit_count
);
  localparam int ACC = WID + MAXLEN;
  localparam int FW  = $clog2(ACC + 1);
  localparam logic [FW-1:0] WID_F = FW'(WID);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [ACC-1:0]  acc, acc_nxt;
  logic [ACC-1:0]  marks, marks_nxt;
  logic [FW-1:0]   fill, fill_nxt, fill_post, shamt;
  logic [ACC-1:0]  code_ext, code_pos, mark_bit;
  logic            pop, accept, flush_done_nxt;

  assign in_ready     = (state == RUN) && (fill <= WID_F);
  assign out_valid    = (fill >= WID_F) || ((state == FLUSH) && (fill != '0));
  assign out_last     = (state == FLUSH) && out_valid && (fill <= WID_F);
  // acc stays zero beyond fill, but the mask keeps the output clean regardless
  assign out_bits     = acc[ACC-1 -: WID] & ~({WID{1'b1}} >> fill);
  assign out_mb_start = marks[ACC-1 -: WID];

  assign pop      = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign code_ext = {{(ACC-MAXLEN){1'b0}}, in_code} & ~({ACC{1'b1}} << in_len);

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    marks_nxt      = marks;
    fill_post      = fill;
    flush_done_nxt = 1'b0;
    if (pop) begin
      acc_nxt   = acc << WID;
      marks_nxt = marks << WID;
      fill_post = (fill > WID_F) ? fill - WID_F : '0;
    end
    // new bits land right after whatever survives this cycle's pop
    shamt    = FW'(ACC) - fill_post - FW'(in_len);
    code_pos = code_ext << shamt;
    mark_bit = {1'b1, {(ACC-1){1'b0}}} >> fill_post;
    fill_nxt = fill_post;
    if (accept) begin
      acc_nxt  = acc_nxt | code_pos;
      fill_nxt = fill_post + FW'(in_len);
      if (in_mb_start)
        marks_nxt = marks_nxt | mark_bit;
      if (in_flush) begin
        if (fill_nxt == '0) begin
          flush_done_nxt = 1'b1;
          marks_nxt      = '0;
        end else begin
          state_nxt = FLUSH;
        end
      end
    end
    if ((state == FLUSH) && pop && (fill <= WID_F)) begin
      state_nxt      = RUN;
      flush_done_nxt = 1'b1;
      acc_nxt        = '0;
      marks_nxt      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      acc        <= '0;
      marks      <= '0;
      fill       <= '0;
      flush_done <= 1'b0;
      bit_count  <= '0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      marks      <= marks_nxt;
      fill       <= fill_nxt;
      flush_done <= flush_done_nxt;
      if (accept)
        bit_count <= bit_count + 32'(in_len);
      if (in_valid)
        assert (int'(in_len) <= MAXLEN);
    end
  end
endmodule

// File: tb/tb_gg_vlc_bit_packer.sv
// Directed bench for gg_vlc_bit_packer (WID=32): hand-computed words, markers, flush and reset behaviour.
module tb_gg_vlc_bit_packer;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_mb_start, in_flush;
  logic [31:0] in_code;
  logic [5:0]  in_len;
  logic        out_valid, out_ready, out_last, flush_done;
  logic [31:0] out_bits, out_mb_start, bit_count;

  int checks = 0;
  int errors = 0;

  logic [127:0] vec = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  gg_vlc_bit_packer #(.WID(32), .MAXLEN(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_len(in_len),
    .in_mb_start(in_mb_start), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_mb_start(out_mb_start), .out_last(out_last),
    .flush_done(flush_done), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] code, input logic [5:0] len,
                      input logic mb, input logic fl);
    int n;
    n = 0;
    in_valid = 1'b1; in_code = code; in_len = len; in_mb_start = mb; in_flush = fl;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("send_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0; in_mb_start = 1'b0; in_flush = 1'b0; in_code = '0; in_len = '0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] bits,
                             input logic [31:0] mark, input logic last);
    int n;
    n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_bits"}, {32'd0, out_bits}, {32'd0, bits});
    check({tag, "_mark"}, {32'd0, out_mb_start}, {32'd0, mark});
    check({tag, "_last"}, {63'd0, out_last}, {63'd0, last});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] seg(input int pos, input int len);
    logic [127:0] t;
    logic [31:0]  m;
    t = vec >> (128 - pos - len);
    m = (len == 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
    return t[31:0] & m;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_code = '0; in_len = '0;
    in_mb_start = 1'b0; in_flush = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_bit_count", {32'd0, bit_count}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_flush_done", {63'd0, flush_done}, 64'd0);

    // 1: short Exp-Golomb symbols, single flushed word
    send(32'h1, 6'd1, 1'b0, 1'b0);
    send(32'h2, 6'd3, 1'b0, 1'b0);
    send(32'h3, 6'd3, 1'b0, 1'b0);
    send(32'h4, 6'd5, 1'b0, 1'b1);
    expect_word("t1_w0", 32'hA640_0000, 32'h0, 1'b1);
    check("t1_flush_done", {63'd0, flush_done}, 64'd1);
    check("t1_bit_count", {32'd0, bit_count}, 64'd12);
    step();
    check("t1_flush_done_pulse", {63'd0, flush_done}, 64'd0);
    check("t1_idle", {63'd0, out_valid}, 64'd0);

    // 2: marker at bit 30 straddling into a second word
    send(32'h3FFF_FFFF, 6'd30, 1'b0, 1'b0);
    send(32'hA, 6'd4, 1'b1, 1'b1);
    expect_word("t2_w0", 32'hFFFF_FFFE, 32'h0000_0002, 1'b0);
    expect_word("t2_w1", 32'h8000_0000, 32'h0, 1'b1);
    check("t2_flush_done", {63'd0, flush_done}, 64'd1);
    check("t2_bit_count", {32'd0, bit_count}, 64'd46);

    // 3: backpressure with a full accumulator
    send(32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);
    send(32'h1234_5678, 6'd32, 1'b0, 1'b0);
    check("t3_full_not_ready", {63'd0, in_ready}, 64'd0);
    step();
    check("t3_hold_bits", {32'd0, out_bits}, 64'hFFFF_FFFF);
    expect_word("t3_w0", 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("t3_ready_back", {63'd0, in_ready}, 64'd1);
    expect_word("t3_w1", 32'h1234_5678, 32'h0, 1'b0);
    check("t3_empty", {63'd0, out_valid}, 64'd0);
    check("t3_bit_count", {32'd0, bit_count}, 64'd110);

    // 4: 128-bit macroblock split into uneven codewords
    send(seg(0, 5), 6'd5, 1'b1, 1'b0);
    send(seg(5, 27), 6'd27, 1'b0, 1'b0);
    send(seg(32, 32), 6'd32, 1'b0, 1'b0);
    expect_word("t4_w0", 32'h0123_4567, 32'h8000_0000, 1'b0);
    send(seg(64, 9), 6'd9, 1'b0, 1'b0);
    expect_word("t4_w1", 32'h89AB_CDEF, 32'h0, 1'b0);
    send(seg(73, 23), 6'd23, 1'b0, 1'b0);
    send(seg(96, 16), 6'd16, 1'b0, 1'b0);
    expect_word("t4_w2", 32'hFEDC_BA98, 32'h0, 1'b0);
    send(seg(112, 16), 6'd16, 1'b0, 1'b1);
    expect_word("t4_w3", 32'h7654_3210, 32'h0, 1'b1);
    check("t4_flush_done", {63'd0, flush_done}, 64'd1);
    check("t4_bit_count", {32'd0, bit_count}, 64'd238);

    // 5: reset discards pending bits
    send(32'hABCDE, 6'd20, 1'b1, 1'b0);
    check("t5_partial_not_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_out_valid", {63'd0, out_valid}, 64'd0);
    check("t5_in_ready", {63'd0, in_ready}, 64'd1);
    check("t5_bit_count", {32'd0, bit_count}, 64'd0);
    send(32'hC3, 6'd8, 1'b0, 1'b1);
    expect_word("t5_w0", 32'hC300_0000, 32'h0, 1'b1);

    // 6: zero-length marker, full-width code, masked upper code bits
    send(32'h0, 6'd0, 1'b1, 1'b0);
    send(32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 6'd3, 1'b0, 1'b1);
    expect_word("t6_w0", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    expect_word("t6_w1", 32'hE000_0000, 32'h0, 1'b1);
    check("t6_bit_count", {32'd0, bit_count}, 64'd43);
    send(32'h0, 6'd0, 1'b0, 1'b1);
    check("t6_empty_flush_done", {63'd0, flush_done}, 64'd1);
    check("t6_empty_flush_no_word", {63'd0, out_valid}, 64'd0);

    // 7: pop and accept in the same cycle
    out_ready = 1'b1;
    send(32'hAAAA_AAAA, 6'd32, 1'b0, 1'b0);
    check("t7_first_valid", {63'd0, out_valid}, 64'd1);
    check("t7_first_bits", {32'd0, out_bits}, 64'hAAAA_AAAA);
    send(32'h5, 6'd4, 1'b0, 1'b1);
    expect_word("t7_w1", 32'h5000_0000, 32'h0, 1'b1);
    check("t7_flush_done", {63'd0, flush_done}, 64'd1);
    check("t7_bit_count", {32'd0, bit_count}, 64'd79);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
